aes_job_ctrl: RTL
=================

// Module: aes_job_ctrl
// PURPOSE
//  Job sequencer between a valid/ready request port and the AES encrypt core (aes_core)
//  and the AES inverse core (invaes_core). It latches one {mode,key,data} job and steers
//  the key/text buses to the selected core. It sequences that core's ce, waits for its
//  done, and returns the result (or a timeout error) on a valid/ready response port.
// PARAMETERS
//  CE_CYCLES   32    clk cycles ce is held high; must span >=2 core slow-clock edges
//  TIMEOUT     4096  max clk cycles in RUN before the job is failed; must be > 0
//  TW          13    timeout counter width; 2**TW > TIMEOUT
// PORTS
//  clk         in   1    system clock
//  reset       in   1    asynchronous, active-high reset
//  in_valid    in   1    job request valid
//  in_ready    out  1    controller can accept a job (IDLE)
//  in_mode     in   1    0 = encrypt (aes_core), 1 = decrypt (invaes_core)
//  in_key      in   128  job key
//  in_data     in   128  plaintext (mode 0) or cyphertext (mode 1)
//  out_valid   out  1    response valid
//  out_ready   in   1    response accepted
//  out_mode    out  1    mode of the returned job
//  out_err     out  1    1 = job timed out, out_data is 0
//  out_data    out  128  core result
//  core_key    out  128  latched key, wired to both cores
//  core_text   out  128  latched data, wired to both cores
//  enc_ce      out  1    aes_core ce
//  enc_done    in   1    aes_core done (slow-clock domain)
//  enc_result  in   128  aes_core cyphertext
//  dec_ce      out  1    invaes_core ce
//  dec_done    in   1    invaes_core done (slow-clock domain)
//  dec_result  in   128  invaes_core plaintext
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; out_err=0; out_mode=0; out_data=0;
//   core_key=0; core_text=0; enc_ce=dec_ce=0; busy=0; counters=0; armed=0.
//  Done sync: enc_done and dec_done each pass through a 2-flop synchronizer (done_s).
//   Only done_s of the selected core (mode register) is used.
//  IDLE: in_ready=1. When in_valid&in_ready: latch mode, core_key<=in_key,
//   core_text<=in_data; go to LOAD next cycle; cnt<=0.
//  LOAD: selected ce=1, other ce=0. cnt increments each cycle. In the cycle cnt==CE_CYCLES-1:
//   go to RUN; ce=0 from the first RUN cycle; cnt<=0; armed<=0.
//  RUN: both ce=0. armed<=1 on the first cycle done_s==0. This rejects a stale done from the
//   previous job. If armed&done_s==1: capture the selected result into out_data; out_err<=0;
//   go to RESP. Otherwise cnt increments. When cnt==TIMEOUT-1 and done is not accepted:
//   out_data<=0, out_err<=1, go to RESP.
//   Done and timeout in the same cycle: done wins.
//  RESP: out_valid=1, with out_data/out_err/out_mode stable. On out_valid&out_ready: go to IDLE;
//   out_valid drops next cycle. out_data keeps its value until the next capture.
//  No job overlap: in_ready=0 in LOAD/RUN/RESP. A new job is accepted at the earliest in the
//   cycle after the RESP handshake.
//  Latency (in_valid&in_ready -> out_valid): CE_CYCLES + core time + sync + 1 clk.
//  ce outputs are registered and glitch-free. Both ce are never high together.
//  core_key/core_text are stable from acceptance until RESP exits.
//  Reset mid-job: all outputs return to reset values at once and the job is dropped.
//   The core sees ce low and is re-initialised by the next LOAD.
//  Toggling in_valid while not ready has no effect. in_* are sampled only at the handshake.
// TESTING
//  1. FIPS-197 C.1 decrypt: mode=1, key=000102..0f, data=69c4e0d86a7b0430d8cdb78070b4c55a
//     -> out_valid, out_err=0, out_data=00112233445566778899aabbccddeeff.
//  2. FIPS-197 C.1 encrypt, same key, data=0011..eeff -> out_data=69c4e0d8..c55a.
//     enc_ce is high for exactly CE_CYCLES clk; dec_ce stays 0 throughout.
//  3. Stale done: dec_done model held high through LOAD, falls, then rises
//     -> the result is captured only after the fall/rise, never in the first RUN cycle.
//  4. Timeout: dec_done stuck 0 -> exactly TIMEOUT clk after RUN entry, out_valid=1,
//     out_err=1, out_data=0; the next job completes normally.
//  5. Backpressure: out_ready=0 for 50 cycles -> out_valid and out_data stay stable and
//     in_ready stays 0; out_ready=1 -> IDLE the next cycle, then back-to-back job 2 is accepted.
//  6. Reset asserted mid-RUN -> every output is at its reset value in the same cycle;
//     after release, job test 1 gives the correct plaintext.

Source files
------------

// File: rtl/aes_job_ctrl_if.sv
// Job request/response handshake bundle for aes_job_ctrl.
// Request and response ports each use a valid/ready pair.
interface aes_job_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_mode;
  logic         out_err;
  logic [127:0] out_data;

  modport master (
    output in_valid,
    output in_mode,
    output in_key,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_mode,
    input  out_err,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_key,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_mode,
    output out_err,
    output out_data
  );
endinterface

// File: rtl/aes_job_ctrl.sv
// Sequences one AES encrypt/decrypt job through aes_core or invaes_core.
// Latches the job, pulses the selected ce, waits for done and returns the result.
module aes_job_ctrl #(
  parameter int CE_CYCLES = 32,
  parameter int TIMEOUT   = 4096,
  parameter int TW        = 13
) (
  input  logic          clk,
  input  logic          reset,
  aes_job_ctrl_if.slave job,
  output logic [127:0]  core_key,
  output logic [127:0]  core_text,
  output logic          enc_ce,
  input  logic          enc_done,
  input  logic [127:0]  enc_result,
  output logic          dec_ce,
  input  logic          dec_done,
  input  logic [127:0]  dec_result,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  localparam logic [TW-1:0] CE_LAST = TW'(CE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  logic [TW-1:0] cnt_q;
  logic          armed_q;
  logic          mode_q;
  logic [127:0]  key_q;
  logic [127:0]  text_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_mode_q;
  logic          out_err_q;
  logic [127:0]  out_data_q;
  logic          enc_ce_q;
  logic          dec_ce_q;
  logic          busy_q;
  logic [1:0]    enc_sync_q;
  logic [1:0]    dec_sync_q;
  logic          done_s;

  // Core done comes from the slow-clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_sync_q <= '0;
      dec_sync_q <= '0;
    end else begin
      enc_sync_q <= {enc_sync_q[0], enc_done};
      dec_sync_q <= {dec_sync_q[0], dec_done};
    end
  end

  assign done_s = mode_q ? dec_sync_q[1] : enc_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      enc_ce_q    <= 1'b0;
      dec_ce_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (job.in_valid) begin
            mode_q     <= job.in_mode;
            key_q      <= job.in_key;
            text_q     <= job.in_data;
            cnt_q      <= '0;
            enc_ce_q   <= ~job.in_mode;
            dec_ce_q   <= job.in_mode;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q == CE_LAST) begin
            enc_ce_q <= 1'b0;
            dec_ce_q <= 1'b0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            state_q  <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          // A done still high from the last job must drop before it counts.
          if (!done_s) armed_q <= 1'b1;
          if (armed_q && done_s) begin
            out_data_q  <= mode_q ? dec_result : enc_result;
            out_err_q   <= 1'b0;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == TO_LAST) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (job.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign job.in_ready  = in_ready_q;
  assign job.out_valid = out_valid_q;
  assign job.out_mode  = out_mode_q;
  assign job.out_err   = out_err_q;
  assign job.out_data  = out_data_q;
  assign core_key      = key_q;
  assign core_text     = text_q;
  assign enc_ce        = enc_ce_q;
  assign dec_ce        = dec_ce_q;
  assign busy          = busy_q;

endmodule
